l2_sqrt: RTL and testbench
==========================

# l2_sqrt

Iterative integer square-root stage directly downstream of the squared-sum accumulator in the L2-norm datapath. Takes the accumulator's 20-bit sum-of-squares with its one-cycle valid strobe. Computes floor(sqrt(sum)) and the remainder with a restoring digit-by-digit algorithm, one result bit per clock. Presents the L2 norm with a one-cycle valid pulse.

## Interface
- SUM_W, 20, radicand width; must be even; matches accumulator output width
- ROOT_W, SUM_W/2 (10), root width; derived, not overridable
- clk  in  1  single clock, all state on posedge
- reset  in  1  synchronous, active-high
- sum  in  SUM_W  radicand, sampled only on an accepted transfer
- valid_in  in  1  radicand valid strobe
- ready  out  1  high when a valid_in will be accepted
- root  out  ROOT_W  floor(sqrt(sum)), held until next result
- rem  out  ROOT_W+1  sum - root², held until next result
- valid_out  out  1  one-cycle pulse, root/rem are new

## Operation
- States: IDLE, CALC, DONE.
- ready = (state != CALC).
- Accept = valid_in & ready. valid_in while ready=0 is ignored: dropped, no error, no effect on the current computation.
- On accept, from IDLE or DONE:
  - load radicand shift reg with sum
  - clear working root (ROOT_W bits) and working remainder (ROOT_W+2 bits)
  - clear iteration counter
  - go to CALC
- Each CALC cycle, one restoring iteration:
  - t = (wrem<<2) | top two radicand bits; radicand <<= 2
  - trial = (wroot<<2) | 1
  - if t ≥ trial: wrem = t - trial, wroot = (wroot<<1) | 1
  - else: wrem = t, wroot = wroot<<1
- Arithmetic is unsigned; no wrap is possible within the given widths.
- On the iteration with counter == ROOT_W-1: root/rem output registers load the final wroot/wrem[ROOT_W:0], and the state goes to DONE.
- DONE lasts one cycle. valid_out = (state == DONE). Next state is CALC on accept, else IDLE.
- The root/rem output registers change only on entry to DONE, so they stay stable during the next computation.
- Reset (any state, including mid-CALC) returns the block to IDLE and discards work in progress:
  - root=0, rem=0
  - valid_out=0, ready=1
  - counter=0, working regs=0

## Timing
- Accept edge E0.
- Iterations at E1..E10. Root/rem update and valid_out rises at E10. valid_out falls at E11 unless re-entered… (it is a single-cycle pulse, high between E10 and E11).
- Latency from accept edge to valid_out high: ROOT_W edges (10).
- ready is low from E0 to E10 and high from E10 (DONE cycle) onward.
- Max throughput: one radicand per ROOT_W+1 cycles, with a new accept allowed in the DONE cycle.
- Upstream accumulator emits at most one valid per input burst, so drops only occur on misuse. Drop behaviour is still defined and tested.

## Structure
- Shared package l2_pkg:
  - SUM_W=20 and ROOT_W=SUM_W/2 constants, also used by the accumulator
  - typedef enum logic [1:0] {IDLE, CALC, DONE} sqrt_state_t
- One natural sub-module, l2_sqrt_step:
  - purely combinational single iteration
  - inputs: wrem, wroot, radicand top pair
  - outputs: next wrem, next wroot
- Top holds the FSM, counter (clog2(ROOT_W) bits), and working and output registers.

## Test plan
- Reset, then sum=0 -> 10 cycles later valid_out pulse, root=0, rem=0. ready returns high in the DONE cycle.
- sum=20'hFFFFF (1048575) -> root=1023, rem=2046; exercises the maximum remainder width.
- sum=65025 -> root=255, rem=0. sum=1000 -> root=31, rem=39. Chain the accumulator with inputs 3, 4, 12 -> sum=169 -> root=13, rem=0.
- Accept sum=1000, assert valid_in with sum=4 at E3..E9 -> those are ignored. Result root=31, rem=39, exactly one valid_out pulse.
- Accept sum=50 (root 7, rem 1), then present sum=144 in the DONE cycle -> accepted. Result root=12, rem=0, ten cycles later. The first result holds until then.
- Accept sum=99, assert reset at E5 -> root=0, rem=0, ready=1, no valid_out. A following sum=99 yields root=9, rem=18.

Source files
------------

// File: rtl/l2_pkg.sv
// Shared constants and types for the L2-norm datapath.
// Radicand and root widths are common to the accumulator and the square-root stage.
package l2_pkg;

  localparam int unsigned SUM_W  = 20;
  localparam int unsigned ROOT_W = SUM_W / 2;
  localparam int unsigned CntW   = $clog2(ROOT_W);

  localparam logic [CntW-1:0] LastIter = CntW'(ROOT_W - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } sqrt_state_t;

endpackage

// File: rtl/l2_sqrt_if.sv
// Radicand-in / root-out handshake bundle for the l2_sqrt stage.
interface l2_sqrt_if;

  logic [l2_pkg::SUM_W-1:0]  sum;
  logic                      valid_in;
  logic                      ready;
  logic [l2_pkg::ROOT_W-1:0] root;
  logic [l2_pkg::ROOT_W:0]   rem;
  logic                      valid_out;

  modport master (
    output sum, valid_in,
    input  ready, root, rem, valid_out
  );

  modport slave (
    input  sum, valid_in,
    output ready, root, rem, valid_out
  );

endinterface

// File: rtl/l2_sqrt_step.sv
// One restoring square-root iteration: consumes one radicand bit pair, yields one root bit.
module l2_sqrt_step
  import l2_pkg::*;
(
  input  logic [ROOT_W+1:0] wrem_i,
  input  logic [ROOT_W-1:0] wroot_i,
  input  logic [1:0]        pair_i,
  output logic [ROOT_W+1:0] wrem_o,
  output logic [ROOT_W-1:0] wroot_o
);

  logic [ROOT_W+1:0] t;
  logic [ROOT_W+1:0] trial;

  // Before the last iteration wrem <= 1022, so dropping its top two bits loses nothing.
  assign t     = {wrem_i[ROOT_W-1:0], pair_i};
  assign trial = {wroot_i, 2'b01};

  always_comb begin
    if (t >= trial) begin
      wrem_o  = t - trial;
      wroot_o = {wroot_i[ROOT_W-2:0], 1'b1};
    end else begin
      wrem_o  = t;
      wroot_o = {wroot_i[ROOT_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/l2_sqrt.sv
// Iterative integer square root: floor(sqrt(sum)) and remainder, one root bit per clock.
// Output registers only change on entry to the done state, so results hold across the next job.
module l2_sqrt
  import l2_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  l2_sqrt_if.slave  bus_io
);

  sqrt_state_t       state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [SUM_W-1:0]  rad_q, rad_d;
  logic [ROOT_W-1:0] wroot_q, wroot_d;
  logic [ROOT_W+1:0] wrem_q, wrem_d;
  logic [ROOT_W-1:0] root_q, root_d;
  logic [ROOT_W:0]   rem_q, rem_d;

  logic [ROOT_W+1:0] step_wrem;
  logic [ROOT_W-1:0] step_wroot;
  logic              accept;

  l2_sqrt_step u_step (
    .wrem_i  (wrem_q),
    .wroot_i (wroot_q),
    .pair_i  (rad_q[SUM_W-1:SUM_W-2]),
    .wrem_o  (step_wrem),
    .wroot_o (step_wroot)
  );

  assign accept = bus_io.valid_in && (state_q != StCalc);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rad_d   = rad_q;
    wroot_d = wroot_q;
    wrem_d  = wrem_q;
    root_d  = root_q;
    rem_d   = rem_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          rad_d   = bus_io.sum;
          wroot_d = '0;
          wrem_d  = '0;
          cnt_d   = '0;
          state_d = StCalc;
        end else begin
          state_d = StIdle;
        end
      end
      StCalc: begin
        rad_d   = {rad_q[SUM_W-3:0], 2'b00};
        wrem_d  = step_wrem;
        wroot_d = step_wroot;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastIter) begin
          root_d  = step_wroot;
          rem_d   = step_wrem[ROOT_W:0];
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rad_q   <= '0;
      wroot_q <= '0;
      wrem_q  <= '0;
      root_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rad_q   <= rad_d;
      wroot_q <= wroot_d;
      wrem_q  <= wrem_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
    end
  end

  assign bus_io.ready     = (state_q != StCalc);
  assign bus_io.valid_out = (state_q == StDone);
  assign bus_io.root      = root_q;
  assign bus_io.rem       = rem_q;

endmodule

// File: tb/tb_l2_sqrt.sv
// Directed bench for l2_sqrt: known radicands, drop-while-busy, back-to-back and mid-job reset.
module tb_l2_sqrt;

  logic clk;
  logic reset;
  int   nchecks;
  int   nerrors;
  int   pulses;

  l2_sqrt_if bus ();

  l2_sqrt dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Accept one radicand, verify busy window, then the result pulse and its fall.
  task automatic run(input string tag, input logic [19:0] s, input int er, input int em);
    bus.sum      = s;
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (bus.valid_out === 1'b1) pulses++;
      if (bus.ready !== 1'b0) check({tag, "_ready_busy"}, 32'(bus.ready), 0);
    end
    check({tag, "_early_pulse"}, pulses, 0);
    tick();
    check({tag, "_valid"}, 32'(bus.valid_out), 1);
    check({tag, "_ready_done"}, 32'(bus.ready), 1);
    check({tag, "_root"}, 32'(bus.root), er);
    check({tag, "_rem"}, 32'(bus.rem), em);
    tick();
    check({tag, "_valid_fall"}, 32'(bus.valid_out), 0);
  endtask

  initial begin
    nchecks      = 0;
    nerrors      = 0;
    reset        = 1'b1;
    bus.sum      = '0;
    bus.valid_in = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_root", 32'(bus.root), 0);
    check("rst_rem", 32'(bus.rem), 0);
    check("rst_ready", 32'(bus.ready), 1);
    check("rst_valid", 32'(bus.valid_out), 0);

    run("zero", 20'd0, 0, 0);
    run("max", 20'hFFFFF, 1023, 2046);
    run("sq255", 20'd65025, 255, 0);
    run("k1000", 20'd1000, 31, 39);
    run("acc169", 20'd169, 13, 0);

    // valid_in with sum=4 held over E3..E9 must be ignored.
    bus.sum      = 20'd1000;
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    tick();
    tick();
    bus.sum      = 20'd4;
    bus.valid_in = 1'b1;
    pulses = 0;
    for (int i = 3; i <= 9; i++) begin
      tick();
      if (bus.valid_out === 1'b1) pulses++;
    end
    bus.valid_in = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.valid_out === 1'b1) begin
        pulses++;
        check("drop_root", 32'(bus.root), 31);
        check("drop_rem", 32'(bus.rem), 39);
      end
    end
    check("drop_pulses", pulses, 1);

    // New job accepted in the DONE cycle; first result must hold until the second lands.
    bus.sum      = 20'd50;
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    for (int i = 1; i <= 9; i++) tick();
    tick();
    check("b2b_valid1", 32'(bus.valid_out), 1);
    check("b2b_root1", 32'(bus.root), 7);
    check("b2b_rem1", 32'(bus.rem), 1);
    bus.sum      = 20'd144;
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    check("b2b_accept_busy", 32'(bus.ready), 0);
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (i == 5) begin
        check("b2b_hold_root", 32'(bus.root), 7);
        check("b2b_hold_rem", 32'(bus.rem), 1);
      end
    end
    tick();
    check("b2b_valid2", 32'(bus.valid_out), 1);
    check("b2b_root2", 32'(bus.root), 12);
    check("b2b_rem2", 32'(bus.rem), 0);
    tick();

    // Reset at E5 of a sum=99 job discards it.
    bus.sum      = 20'd99;
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    for (int i = 1; i <= 4; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_root", 32'(bus.root), 0);
    check("mid_rst_rem", 32'(bus.rem), 0);
    check("mid_rst_ready", 32'(bus.ready), 1);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.valid_out === 1'b1) pulses++;
      tick();
    end
    check("mid_rst_no_pulse", pulses, 0);
    run("after_rst", 20'd99, 9, 18);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
